// File: rtl/rmii_rx_frame_deframer.sv
// RMII receive deframer: hunts preamble+SFD, packs dibits LSB-first into bytes,
// checks the Ethernet FCS and reports per-frame status on a done strobe.
module rmii_rx_frame_deframer #(
  parameter int MIN_PRE = 8,
  parameter int MAX_LEN = 1522,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_erxd,
  input  logic             i_erx_dv,
  input  logic             i_erx_er,
  output logic [7:0]       o_data,
  output logic             o_data_valid,
  output logic             o_sof,
  output logic             o_frame_done,
  output logic             o_crc_ok,
  output logic             o_align_err,
  output logic             o_rx_err,
  output logic             o_too_long,
  output logic [LEN_W-1:0] o_len
);

  localparam int PRE_W = $clog2(MIN_PRE + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Handshake: o_data_valid/o_frame_done are one-cycle strobes with no ready;
  // the consumer must take every byte (at most one per four cycles).

  logic [1:0]       state_q, state_d;
  logic             dv_q, dv_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rx_err_q, rx_err_d;
  logic             too_long_q, too_long_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             sof_q, sof_d;
  logic             frame_done_q, frame_done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             align_err_q, align_err_d;
  logic             rx_err_out_q, rx_err_out_d;
  logic             too_long_out_q, too_long_out_d;
  logic [LEN_W-1:0] len_out_q, len_out_d;
  logic [7:0]       full_byte;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  assign full_byte = {i_erxd, byte_q[5:0]};

  always_comb begin
    state_d        = state_q;
    dv_d           = i_erx_dv;
    pre_cnt_d      = pre_cnt_q;
    phase_d        = phase_q;
    byte_d         = byte_q;
    crc_d          = crc_q;
    len_d          = len_q;
    rx_err_d       = rx_err_q;
    too_long_d     = too_long_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    sof_d          = 1'b0;
    frame_done_d   = 1'b0;
    crc_ok_d       = crc_ok_q;
    align_err_d    = align_err_q;
    rx_err_out_d   = rx_err_out_q;
    too_long_out_d = too_long_out_q;
    len_out_d      = len_out_q;

    case (state_q)
      ST_IDLE: begin
        if (!dv_q && i_erx_dv) begin
          if (i_erxd == 2'b01) begin
            state_d   = ST_PRE;
            pre_cnt_d = PRE_W'(1);
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!i_erx_dv) begin
          state_d = ST_IDLE;
        end else if (i_erxd == 2'b01) begin
          if (pre_cnt_q < PRE_W'(MIN_PRE)) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (i_erxd == 2'b11 && pre_cnt_q >= PRE_W'(MIN_PRE)) begin
          state_d    = ST_DATA;
          crc_d      = 32'hFFFFFFFF;
          len_d      = '0;
          phase_d    = 2'd0;
          byte_d     = 8'h00;
          rx_err_d   = 1'b0;
          too_long_d = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (i_erx_dv) begin
          if (i_erx_er) rx_err_d = 1'b1;
          byte_d[{phase_q, 1'b0} +: 2] = i_erxd;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            crc_d = crc_byte(crc_q, full_byte);
            if (len_q != {LEN_W{1'b1}}) len_d = len_q + 1'b1;
            if (len_q < LEN_W'(MAX_LEN)) begin
              data_d       = full_byte;
              data_valid_d = 1'b1;
              sof_d        = (len_q == '0);
            end else begin
              too_long_d = 1'b1;
            end
          end
        end else begin
          // Partial trailing byte is dropped; crc_q/len_q already exclude it.
          state_d        = ST_IDLE;
          frame_done_d   = 1'b1;
          crc_ok_d       = (rev32(crc_q) == 32'hC704DD7B);
          align_err_d    = (phase_q != 2'd0);
          rx_err_out_d   = rx_err_q;
          too_long_out_d = too_long_q;
          len_out_d      = len_q;
        end
      end
      default: begin
        if (!i_erx_dv) state_d = ST_IDLE;
      end
    endcase
  end

  // dv_q resets high so a reset inside a frame cannot see a false dv rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dv_q           <= 1'b1;
      pre_cnt_q      <= '0;
      phase_q        <= 2'd0;
      byte_q         <= 8'h00;
      crc_q          <= 32'hFFFFFFFF;
      len_q          <= '0;
      rx_err_q       <= 1'b0;
      too_long_q     <= 1'b0;
      data_q         <= 8'h00;
      data_valid_q   <= 1'b0;
      sof_q          <= 1'b0;
      frame_done_q   <= 1'b0;
      crc_ok_q       <= 1'b0;
      align_err_q    <= 1'b0;
      rx_err_out_q   <= 1'b0;
      too_long_out_q <= 1'b0;
      len_out_q      <= '0;
    end else begin
      state_q        <= state_d;
      dv_q           <= dv_d;
      pre_cnt_q      <= pre_cnt_d;
      phase_q        <= phase_d;
      byte_q         <= byte_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      rx_err_q       <= rx_err_d;
      too_long_q     <= too_long_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      sof_q          <= sof_d;
      frame_done_q   <= frame_done_d;
      crc_ok_q       <= crc_ok_d;
      align_err_q    <= align_err_d;
      rx_err_out_q   <= rx_err_out_d;
      too_long_out_q <= too_long_out_d;
      len_out_q      <= len_out_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_sof        = sof_q;
  assign o_frame_done = frame_done_q;
  assign o_crc_ok     = crc_ok_q;
  assign o_align_err  = align_err_q;
  assign o_rx_err     = rx_err_out_q;
  assign o_too_long   = too_long_out_q;
  assign o_len        = len_out_q;

endmodule
